// File: rtl/mult_ctrl_fsm.sv
// Control sequencer for the shift-free repeated-addition multiplier.
// Moore outputs only; cyc_cnt_o records busy cycles of the last/current operation.
module mult_ctrl_fsm #(
    parameter int CW = 8
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          done_ack_i,
    input  logic          zero_val_i,
    output logic          load_p_o,
    output logic          load_q_o,
    output logic          clr_f_o,
    output logic          load_f_o,
    output logic          dec_q_o,
    output logic [1:0]    opnd_req_o,
    output logic          ready_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] cyc_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_P = 3'd1,
        S_LOAD_Q = 3'd2,
        S_CHECK  = 3'd3,
        S_ADD    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
    logic          busy_w;

    assign busy_w = (state_q == S_LOAD_P) || (state_q == S_LOAD_Q) ||
                    (state_q == S_CHECK)  || (state_q == S_ADD);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            cyc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cyc_cnt_d = cyc_cnt_q;
        if (busy_w && (cyc_cnt_q != '1))
            cyc_cnt_d = cyc_cnt_q + CW'(1);
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_LOAD_P;
                    cyc_cnt_d = '0;
                end
            end
            S_LOAD_P: state_d = S_LOAD_Q;
            S_LOAD_Q: state_d = S_CHECK;
            S_CHECK:  state_d = zero_val_i ? S_DONE : S_ADD;
            S_ADD:    state_d = S_CHECK;
            S_DONE: begin
                if (done_ack_i)
                    state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
        // An abandoned operation keeps the count it had reached.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            cyc_cnt_d = cyc_cnt_q;
        end
    end

    always_comb begin
        load_p_o   = 1'b0;
        load_q_o   = 1'b0;
        clr_f_o    = 1'b0;
        load_f_o   = 1'b0;
        dec_q_o    = 1'b0;
        opnd_req_o = 2'b00;
        ready_o    = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            S_IDLE:   ready_o = 1'b1;
            S_LOAD_P: begin
                load_p_o   = 1'b1;
                clr_f_o    = 1'b1;
                opnd_req_o = 2'b01;
            end
            S_LOAD_Q: begin
                load_q_o   = 1'b1;
                opnd_req_o = 2'b10;
            end
            S_ADD: begin
                load_f_o = 1'b1;
                dec_q_o  = 1'b1;
            end
            S_DONE:   done_o = 1'b1;
            default:  ;
        endcase
    end

    assign busy_o    = busy_w;
    assign cyc_cnt_o = cyc_cnt_q;

endmodule

// File: tb/tb_mult_ctrl_fsm.sv
// Directed bench for mult_ctrl_fsm with a behavioural P/Q/F datapath around it.
module tb_mult_ctrl_fsm;

    localparam int CW = 8;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          done_ack_i = 1'b0;
    logic          zero_val_i;
    logic          load_p_o, load_q_o, clr_f_o, load_f_o, dec_q_o;
    logic [1:0]    opnd_req_o;
    logic          ready_o, busy_o, done_o;
    logic [CW-1:0] cyc_cnt_o;

    logic [7:0] p_val = '0, m_val = '0;
    logic [7:0] p_r = '0, q_r = '0, f_r = '0;
    logic [7:0] in_data;

    int n_vec  = 0;
    int n_miss = 0;

    mult_ctrl_fsm #(.CW(CW)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .done_ack_i (done_ack_i),
        .zero_val_i (zero_val_i),
        .load_p_o   (load_p_o),
        .load_q_o   (load_q_o),
        .clr_f_o    (clr_f_o),
        .load_f_o   (load_f_o),
        .dec_q_o    (dec_q_o),
        .opnd_req_o (opnd_req_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .cyc_cnt_o  (cyc_cnt_o)
    );

    always #5 clk_in = ~clk_in;

    // Host drives the requested operand; datapath registers follow the strobes.
    assign in_data    = (opnd_req_o == 2'b01) ? p_val : (opnd_req_o == 2'b10) ? m_val : 8'd0;
    assign zero_val_i = (q_r == 8'd0);

    always @(posedge clk_in) begin
        if (load_p_o) p_r <= in_data;
        if (load_q_o) q_r <= in_data;
        if (clr_f_o)  f_r <= 8'd0;
        else if (load_f_o) f_r <= f_r + p_r;
        if (dec_q_o)  q_r <= q_r - 8'd1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int strobes();
        return {27'd0, load_p_o, load_q_o, clr_f_o, load_f_o, dec_q_o};
    endfunction

    // Presents start across one rising edge (edge 0); returns just after it.
    task automatic start_op(input logic [7:0] p, input logic [7:0] m, input bit hold);
        @(negedge clk_in);
        p_val   = p;
        m_val   = m;
        start_i = 1'b1;
        @(posedge clk_in);
        #1;
        if (!hold) start_i = 1'b0;
    endtask

    // Counts cycles from edge 0 until done_o, recording ADD pulses and operand requests.
    task automatic run_to_done(output int cyc, output int adds, output int op1,
                               output int op2, output int excl_bad);
        cyc = 0; adds = 0; op1 = -1; op2 = -1; excl_bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc++;
            @(negedge clk_in);
            if (load_f_o) adds++;
            if ((int'(load_p_o) + int'(load_q_o) + int'(load_f_o)) > 1) excl_bad++;
            if (dec_q_o && !load_f_o) excl_bad++;
            if (cyc == 1) op1 = int'(opnd_req_o);
            if (cyc == 2) op2 = int'(opnd_req_o);
            if (done_o) return;
            @(posedge clk_in);
        end
        cyc = -1;
    endtask

    task automatic ack_done();
        @(negedge clk_in);
        done_ack_i = 1'b1;
        @(posedge clk_in);
        #1;
        done_ack_i = 1'b0;
    endtask

    initial begin
        int cyc, adds, op1, op2, bad, n;

        // Power-up reset
        repeat (2) @(negedge clk_in);
        chk("rst_ready", int'(ready_o), 1);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_cnt", int'(cyc_cnt_o), 0);
        chk("rst_strobes", strobes(), 0);
        chk("rst_opnd", int'(opnd_req_o), 0);
        rst_in = 1'b1;

        // 2: P=5, Q=3
        start_op(8'd5, 8'd3, 1'b0);
        run_to_done(cyc, adds, op1, op2, bad);
        chk("t2_done_cyc", cyc, 10);
        chk("t2_op1", op1, 1);
        chk("t2_op2", op2, 2);
        chk("t2_adds", adds, 3);
        chk("t2_excl", bad, 0);
        chk("t2_F", int'(f_r), 15);
        chk("t2_cnt", int'(cyc_cnt_o), 9);
        ack_done();
        @(negedge clk_in);
        chk("t2_idle_ready", int'(ready_o), 1);
        chk("t2_cnt_hold", int'(cyc_cnt_o), 9);

        // 3: P=7, Q=0
        start_op(8'd7, 8'd0, 1'b0);
        run_to_done(cyc, adds, op1, op2, bad);
        chk("t3_done_cyc", cyc, 4);
        chk("t3_adds", adds, 0);
        chk("t3_F", int'(f_r), 0);
        chk("t3_cnt", int'(cyc_cnt_o), 3);
        ack_done();

        // 4: P=15, Q=15 and hold DONE without ack
        start_op(8'd15, 8'd15, 1'b0);
        run_to_done(cyc, adds, op1, op2, bad);
        chk("t4_done_cyc", cyc, 34);
        chk("t4_adds", adds, 15);
        chk("t4_excl", bad, 0);
        chk("t4_F", int'(f_r), 225);
        chk("t4_cnt", int'(cyc_cnt_o), 33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            chk("t4_hold_done", int'(done_o), 1);
            chk("t4_hold_strobes", strobes(), 0);
        end
        chk("t4_hold_F", int'(f_r), 225);
        ack_done();

        // 5: abort during 2nd ADD of P=4, Q=6
        start_op(8'd4, 8'd6, 1'b0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (load_f_o) n++;
            if (n == 2) break;
            @(posedge clk_in);
        end
        chk("t5_reach_add2", n, 2);
        abort_i = 1'b1;
        @(posedge clk_in);
        #1;
        abort_i = 1'b0;
        @(negedge clk_in);
        chk("t5_ready", int'(ready_o), 1);
        chk("t5_busy", int'(busy_o), 0);
        chk("t5_dec_q", int'(dec_q_o), 0);
        chk("t5_strobes", strobes(), 0);
        chk("t5_cnt_hold", int'(cyc_cnt_o), 5);
        start_op(8'd2, 8'd2, 1'b0);
        run_to_done(cyc, adds, op1, op2, bad);
        chk("t5_done_cyc", cyc, 8);
        chk("t5_F", int'(f_r), 4);
        chk("t5_cnt", int'(cyc_cnt_o), 7);
        ack_done();

        // 6: start held high through busy and DONE
        start_op(8'd3, 8'd1, 1'b1);
        run_to_done(cyc, adds, op1, op2, bad);
        chk("t6_done_cyc", cyc, 6);
        chk("t6_F", int'(f_r), 3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            chk("t6_no_restart", int'(done_o), 1);
            chk("t6_busy", int'(busy_o), 0);
        end
        ack_done();
        @(negedge clk_in);
        chk("t6_ack_idle", int'(ready_o), 1);
        chk("t6_ack_done_low", int'(done_o), 0);
        @(posedge clk_in);
        @(negedge clk_in);
        chk("t6_restart_busy", int'(busy_o), 1);
        chk("t6_restart_opnd", int'(opnd_req_o), 1);
        start_i = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (done_o) begin n = 1; break; end
            @(posedge clk_in);
        end
        chk("t6_second_done", n, 1);
        chk("t6_second_F", int'(f_r), 3);
        ack_done();

        // 1: async reset mid-ADD
        start_op(8'd5, 8'd3, 1'b0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (load_f_o) begin n = 1; break; end
            @(posedge clk_in);
        end
        chk("t1_reach_add", n, 1);
        rst_in = 1'b0;
        #1;
        chk("t1_ready", int'(ready_o), 1);
        chk("t1_strobes", strobes(), 0);
        chk("t1_busy", int'(busy_o), 0);
        chk("t1_cnt", int'(cyc_cnt_o), 0);
        @(posedge clk_in);
        @(negedge clk_in);
        chk("t1_still_idle", strobes(), 0);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("t1_after_release", int'(ready_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
